// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, coordinate types and the registered
// sync/active control bundle used by the raster timing generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef logic [HW-1:0] vga_x_t;
    typedef logic [VW-1:0] vga_y_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } vga_ctrl_t;

    // Pin level for a sync: neg=1 makes an asserted sync drive low.
    function automatic logic sync_level(input logic act, input logic neg);
        return act ^ neg;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video timing bundle from the raster generator to the pixel source / DAC.
// Colour signals exist only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
    parameter int HW = vga_pkg::HW,
    parameter int VW = vga_pkg::VW
);
    logic          hsync_o;
    logic          vsync_o;
    logic          active_video_o;
    logic [HW-1:0] pixel_x_o;
    logic [VW-1:0] pixel_y_o;
    logic          line_start_o;
    logic          frame_start_o;
`ifdef VGA_TEST_PATTERN_EN
    logic [3:0]    r_o;
    logic [3:0]    g_o;
    logic [3:0]    b_o;

    modport master (output hsync_o, vsync_o, active_video_o, pixel_x_o, pixel_y_o,
                    line_start_o, frame_start_o, r_o, g_o, b_o);
    modport slave  (input  hsync_o, vsync_o, active_video_o, pixel_x_o, pixel_y_o,
                    line_start_o, frame_start_o, r_o, g_o, b_o);
`else
    modport master (output hsync_o, vsync_o, active_video_o, pixel_x_o, pixel_y_o,
                    line_start_o, frame_start_o);
    modport slave  (input  hsync_o, vsync_o, active_video_o, pixel_x_o, pixel_y_o,
                    line_start_o, frame_start_o);
`endif
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus combinational decode of the
// active region and the (polarity-free) sync window for the current count.
module vga_axis_counter #(
    parameter  int ACTIVE = 640,
    parameter  int FP     = 16,
    parameter  int SYNC   = 96,
    parameter  int BP     = 48,
    localparam int TOTAL  = ACTIVE + FP + SYNC + BP,
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    input  logic         wrap_en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] count_q, count_d;

    // The last count is the only wrap point; without wrap_en_i it parks there.
    always_comb begin
        count_d = count_q;
        wrap_o  = inc_i && (count_q == LAST);
        if (inc_i) begin
            if (count_q != LAST) begin
                count_d = count_q + W'(1);
            end else if (wrap_en_i) begin
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = (count_q < ACT_END);
    assign sync_o   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: H/V counters decoded into registered syncs, active
// video, coordinates and start pulses. VGA_TEST_PATTERN_EN adds colour bars.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter bit SYNC_NEG = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    vga_timing_gen_if.master    vga
);
    import vga_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam vga_ctrl_t CTRL_IDLE = '{hsync: SYNC_NEG, vsync: SYNC_NEG, active: 1'b0};

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_act, h_sync;
    logic          v_wrap, v_act, v_sync;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (enable_i),
        .wrap_en_i(1'b1),
        .count_o  (h_cnt),
        .wrap_o   (h_wrap),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    // Stepping V only on the H wrap keeps vsync edges aligned to line starts.
    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (h_wrap),
        .wrap_en_i(1'b1),
        .count_o  (v_cnt),
        .wrap_o   (v_wrap),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    v_wrap_needs_h_wrap: assert property (@(posedge clk_i) disable iff (!rst_ni) v_wrap |-> h_wrap);

    vga_ctrl_t     ctrl_q, ctrl_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Disabled: syncs idle and pulses drop while coordinates hold the last shown position.
    always_comb begin
        ctrl_d.hsync  = sync_level(enable_i & h_sync, SYNC_NEG);
        ctrl_d.vsync  = sync_level(enable_i & v_sync, SYNC_NEG);
        ctrl_d.active = enable_i & h_act & v_act;
        x_d           = enable_i ? h_cnt : x_q;
        y_d           = enable_i ? v_cnt : y_q;
        line_start_d  = enable_i && (h_cnt == '0);
        frame_start_d = line_start_d && (v_cnt == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q        <= CTRL_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hsync_o        = ctrl_q.hsync;
    assign vga.vsync_o        = ctrl_q.vsync;
    assign vga.active_video_o = ctrl_q.active;
    assign vga.pixel_x_o      = x_q;
    assign vga.pixel_y_o      = y_q;
    assign vga.line_start_o   = line_start_q;
    assign vga.frame_start_o  = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        bar = '0;
        for (int k = 1; k < 8; k++) begin
            if (h_cnt >= HW'(k * BAR_W)) bar = 3'(k);
        end
        rgb_d = '0;
        if (ctrl_d.active) begin
            rgb_d = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign vga.r_o = rgb_q[11:8];
    assign vga.g_o = rgb_q[7:4];
    assign vga.b_o = rgb_q[3:0];
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line-level
// timing, hold and reset, plus a shrunken active-high instance for frame timing.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b1;
    int   checks = 0;
    int   errors = 0;

    vga_timing_gen_if #(.HW(HW), .VW(VW)) vga ();
    vga_timing_gen_if #(.HW(5), .VW(5))   vs ();

    vga_timing_gen dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .enable_i(en),
        .vga     (vga)
    );

    // 24 cycles/line, 19 lines/frame, hsync x=18..21, vsync lines 14..15, active-high.
    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_NEG(1'b0)
    ) dut_s (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .enable_i(en),
        .vga     (vs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_xy(input int x, input int y, input int budget);
        int n = 0;
        while (!(vga.pixel_x_o == x && vga.pixel_y_o == y) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_xy timeout", n, 0);
    endtask

    task automatic cycles_to_line_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vga.line_start_o && n < 1000);
    endtask

    initial begin
        int lo, lo_min, lo_max, ls_cnt, act_cnt, n, moved;
        int vs_hi, vy_min, vy_max, hs_hi, fs_cnt, x_max, y_max;

        // Reset values, then the first frame_start one cycle after release.
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        check("rst hsync", vga.hsync_o, 1);
        check("rst vsync", vga.vsync_o, 1);
        check("rst active", vga.active_video_o, 0);
        check("rst x", vga.pixel_x_o, 0);
        check("rst y", vga.pixel_y_o, 0);
        check("rst line_start", vga.line_start_o, 0);
        check("rst frame_start", vga.frame_start_o, 0);
        check("rst small hsync", vs.hsync_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first frame_start", vga.frame_start_o, 1);
        check("first line_start", vga.line_start_o, 1);
        check("first x", vga.pixel_x_o, 0);
        check("first active", vga.active_video_o, 1);
        check("small first frame_start", vs.frame_start_o, 1);
        @(negedge clk);
        check("frame_start one cycle", vga.frame_start_o, 0);
        check("second x", vga.pixel_x_o, 1);

        // One full line from x=1 through x=0 of line 1.
        lo = 0; lo_min = 9999; lo_max = -1; ls_cnt = 0; act_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (vga.hsync_o == 1'b0) begin
                lo++;
                if (int'(vga.pixel_x_o) < lo_min) lo_min = int'(vga.pixel_x_o);
                if (int'(vga.pixel_x_o) > lo_max) lo_max = int'(vga.pixel_x_o);
            end
            if (vga.line_start_o) ls_cnt++;
            if (vga.active_video_o) act_cnt++;
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 639) check("active x639", vga.active_video_o, 1);
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 640) check("active x640", vga.active_video_o, 0);
`ifdef VGA_TEST_PATTERN_EN
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 79)  check("rgb x79", {vga.r_o, vga.g_o, vga.b_o}, 12'h000);
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 80)  check("rgb x80", {vga.r_o, vga.g_o, vga.b_o}, 12'h00F);
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 639) check("rgb x639", {vga.r_o, vga.g_o, vga.b_o}, 12'hFFF);
            if (vga.pixel_y_o == 0 && vga.pixel_x_o == 640) check("rgb x640", {vga.r_o, vga.g_o, vga.b_o}, 12'h000);
`endif
            @(negedge clk);
        end
        check("hsync low cycles", lo, 96);
        check("hsync first x", lo_min, 656);
        check("hsync last x", lo_max, 751);
        check("line_start per line", ls_cnt, 1);
        check("active per line", act_cnt, 640);
        check("line wrap x", vga.pixel_x_o, 1);
        check("line wrap y", vga.pixel_y_o, 1);
        check("vsync idle early", vga.vsync_o, 1);
        cycles_to_line_start(n);
        check("line_start align", n, 799);
        cycles_to_line_start(n);
        check("line period", n, 800);

        // Enable dropped at (100,5) for 20 cycles.
        wait_xy(100, 5, 5000);
        en = 1'b0;
        moved = 0;
        repeat (20) begin
            @(negedge clk);
            if (vga.pixel_x_o != 100 || vga.pixel_y_o != 5) moved++;
        end
        check("hold moved", moved, 0);
        check("hold x", vga.pixel_x_o, 100);
        check("hold y", vga.pixel_y_o, 5);
        check("hold hsync", vga.hsync_o, 1);
        check("hold vsync", vga.vsync_o, 1);
        check("hold active", vga.active_video_o, 0);
        check("hold line_start", vga.line_start_o, 0);
        en = 1'b1;
        @(negedge clk);
        check("resume x", vga.pixel_x_o, 101);
        check("resume y", vga.pixel_y_o, 5);
        check("resume active", vga.active_video_o, 1);

        // Asynchronous reset in the middle of hsync at (700,30).
        wait_xy(700, 30, 30000);
        check("pre reset hsync", vga.hsync_o, 0);
        rst_n = 1'b0;
        #1;
        check("async rst x", vga.pixel_x_o, 0);
        check("async rst y", vga.pixel_y_o, 0);
        check("async rst hsync", vga.hsync_o, 1);
        check("async rst active", vga.active_video_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart frame_start", vga.frame_start_o, 1);
        check("restart x", vga.pixel_x_o, 0);
        check("restart y", vga.pixel_y_o, 0);
        @(negedge clk);
        check("restart next x", vga.pixel_x_o, 1);
        check("restart next y", vga.pixel_y_o, 0);

        // Whole-frame behaviour on the small active-high instance.
        n = 0;
        while (!vs.frame_start_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("small frame_start timeout", n, 0);
        vs_hi = 0; vy_min = 99; vy_max = -1; hs_hi = 0; act_cnt = 0;
        fs_cnt = 0; ls_cnt = 0; x_max = 0; y_max = 0;
        for (int i = 0; i < 456; i++) begin
            if (vs.vsync_o) begin
                vs_hi++;
                if (int'(vs.pixel_y_o) < vy_min) vy_min = int'(vs.pixel_y_o);
                if (int'(vs.pixel_y_o) > vy_max) vy_max = int'(vs.pixel_y_o);
            end
            if (vs.hsync_o) hs_hi++;
            if (vs.active_video_o) act_cnt++;
            if (vs.frame_start_o) fs_cnt++;
            if (vs.line_start_o) ls_cnt++;
            if (int'(vs.pixel_x_o) > x_max) x_max = int'(vs.pixel_x_o);
            if (int'(vs.pixel_y_o) > y_max) y_max = int'(vs.pixel_y_o);
            @(negedge clk);
        end
        check("small vsync cycles", vs_hi, 48);
        check("small vsync first line", vy_min, 14);
        check("small vsync last line", vy_max, 15);
        check("small hsync cycles", hs_hi, 76);
        check("small active cycles", act_cnt, 192);
        check("small frame_start count", fs_cnt, 1);
        check("small line_start count", ls_cnt, 19);
        check("small max x", x_max, 23);
        check("small max y", y_max, 18);
        check("small frame period", vs.frame_start_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
